// File: rtl/tone_period_meter.sv
// Period / high-time meter for an asynchronous square-wave input, reporting each full period with a strobe.
// Optional glitch filter on the synchronised input: define TONE_GLITCH_FILTER_EN.
module tone_period_meter #(
  parameter int CNT_W      = 20,
  parameter int MIN_PERIOD = 16,
  parameter int FILT_LEN   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cycles,
  output logic             period_valid,
  output logic             silent
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  logic             sync1;
  logic             sync2;
  logic             s;
  logic             s_d;
  logic             rise;
  logic             accept;
  logic             timeout;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cnt;

  if (FILT_LEN < 1) begin : g_filt_len_check
    $error("tone_period_meter: FILT_LEN must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
    end
  end

`ifdef TONE_GLITCH_FILTER_EN
  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic            filt;
  logic [FC_W-1:0] fcnt;

  // The filtered level flips only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (sync2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FC_W'(FILT_LEN - 1)) begin
      filt <= sync2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign s = filt;
`else
  assign s = sync2;
`endif

  assign rise    = s & ~s_d;
  assign accept  = rise && (cnt >= CNT_W'(MIN_PERIOD));
  assign timeout = (cnt == {CNT_W{1'b1}});

  // An accepted rise takes priority over timeout, so a full-range period is still reported.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      s_d          <= 1'b0;
      cnt          <= '0;
      hi_cnt       <= '0;
      period       <= '0;
      high_cycles  <= '0;
      period_valid <= 1'b0;
      silent       <= 1'b1;
    end else begin
      s_d          <= s;
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt    <= CNT_W'(1);
            hi_cnt <= CNT_W'(1);
            state  <= MEASURE;
          end
        end
        MEASURE: begin
          if (accept) begin
            period       <= cnt;
            high_cycles  <= hi_cnt;
            period_valid <= 1'b1;
            silent       <= 1'b0;
            cnt          <= CNT_W'(1);
            hi_cnt       <= CNT_W'(1);
          end else if (timeout) begin
            silent <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt    <= cnt + 1'b1;
            hi_cnt <= hi_cnt + CNT_W'(s);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// Scoreboard bench for tone_period_meter: a 20-bit instance for the main tests, an 8-bit one for silence timeout.
module tb_tone_period_meter;

  localparam int CW_A = 20;
  localparam int CW_B = 8;
`ifdef TONE_GLITCH_FILTER_EN
  localparam int LAT       = 3 + 4;
  localparam int GLITCH_HI = 100;
`else
  localparam int LAT       = 3;
  localparam int GLITCH_HI = 98;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic            tone_a;
  logic            tone_b;
  logic [CW_A-1:0] period_a;
  logic [CW_A-1:0] high_a;
  logic            valid_a;
  logic            silent_a;
  logic [CW_B-1:0] period_b;
  logic [CW_B-1:0] high_b;
  logic            valid_b;
  logic            silent_b;

  tone_period_meter dut_a (
    .clk          (clk),
    .resetn       (resetn),
    .tone_in      (tone_a),
    .period       (period_a),
    .high_cycles  (high_a),
    .period_valid (valid_a),
    .silent       (silent_a)
  );

  tone_period_meter #(.CNT_W(CW_B)) dut_b (
    .clk          (clk),
    .resetn       (resetn),
    .tone_in      (tone_b),
    .period       (period_b),
    .high_cycles  (high_b),
    .period_valid (valid_b),
    .silent       (silent_b)
  );

  typedef struct {
    int unsigned per;
    int unsigned hi;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   strobe_cyc_b = 0;
  logic prev_va = 1'b0;
  logic prev_vb = 1'b0;

  // Advance one cycle and retire any strobe against the scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (valid_a) begin
      vectors++;
      if (prev_va) begin
        miscompares++;
        $display("FAIL strobe_a_width: valid high two cycles in a row, required one");
      end
      vectors++;
      if (q_a.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_a: unexpected strobe period=%0d high=%0d, required none", period_a, high_a);
      end else begin
        e = q_a.pop_front();
        if (period_a !== CW_A'(e.per) || high_a !== CW_A'(e.hi) || (cyc - e.cyc) != LAT) begin
          miscompares++;
          $display("FAIL strobe_a: period=%0d high=%0d latency=%0d, required period=%0d high=%0d latency=%0d",
                   period_a, high_a, cyc - e.cyc, e.per, e.hi, LAT);
        end else begin
          $display("strobe_a ok: period=%0d high=%0d", period_a, high_a);
        end
      end
    end
    if (valid_b) begin
      strobe_cyc_b = cyc;
      vectors++;
      if (q_b.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_b: unexpected strobe period=%0d high=%0d, required none", period_b, high_b);
      end else begin
        e = q_b.pop_front();
        if (period_b !== CW_B'(e.per) || high_b !== CW_B'(e.hi) || (cyc - e.cyc) != LAT || prev_vb) begin
          miscompares++;
          $display("FAIL strobe_b: period=%0d high=%0d latency=%0d, required period=%0d high=%0d latency=%0d",
                   period_b, high_b, cyc - e.cyc, e.per, e.hi, LAT);
        end else begin
          $display("strobe_b ok: period=%0d high=%0d", period_b, high_b);
        end
      end
    end
    prev_va = valid_a;
    prev_vb = valid_b;
  endtask

  task automatic expect_a(input int unsigned per, input int unsigned hi);
    exp_t e;
    e.per = per; e.hi = hi; e.cyc = cyc;
    q_a.push_back(e);
  endtask

  task automatic expect_b(input int unsigned per, input int unsigned hi);
    exp_t e;
    e.per = per; e.hi = hi; e.cyc = cyc;
    q_b.push_back(e);
  endtask

  task automatic wave_a(input int hi, input int lo);
    tone_a = 1'b1;
    repeat (hi) step();
    tone_a = 1'b0;
    repeat (lo) step();
  endtask

  task automatic wave_b(input int hi, input int lo);
    tone_b = 1'b1;
    repeat (hi) step();
    tone_b = 1'b0;
    repeat (lo) step();
  endtask

  task automatic apply_reset();
    tone_a = 1'b0;
    tone_b = 1'b0;
    resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    repeat (2) step();
  endtask

  task automatic drain(input string name);
    repeat (LAT + 5) step();
    vectors++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d/%0d strobes outstanding, required 0/0", name, q_a.size(), q_b.size());
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tone_a = ~tone_a;
      tone_b = ~tone_b;
      step();
      vectors++;
      if (silent_a !== 1'b1 || period_a !== '0 || high_a !== '0 || valid_a !== 1'b0 ||
          silent_b !== 1'b1 || period_b !== '0 || high_b !== '0 || valid_b !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_%0d: silent=%b period=%0d high=%0d valid=%b, required 1/0/0/0",
                 i, silent_a, period_a, high_a, valid_a);
      end else begin
        $display("reset_%0d ok", i);
      end
    end
    tone_a = 1'b0;
    tone_b = 1'b0;
    resetn = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_square();
    apply_reset();
    wave_a(50, 50);
    vectors++;
    if (silent_a !== 1'b1) begin
      miscompares++;
      $display("FAIL square_armed_silent: silent=%b, required 1", silent_a);
    end
    expect_a(100, 50);
    wave_a(50, 50);
    vectors++;
    if (silent_a !== 1'b0) begin
      miscompares++;
      $display("FAIL square_silent_fall: silent=%b, required 0", silent_a);
    end
    expect_a(100, 50);
    wave_a(50, 50);
    expect_a(100, 50);
    wave_a(50, 50);
    drain("square");
  endtask

  task automatic test_beep();
    apply_reset();
    wave_a(32768, 32768);
    expect_a(65536, 32768);
    tone_a = 1'b1;
    repeat (LAT + 5) step();
    vectors++;
    if (silent_a !== 1'b0) begin
      miscompares++;
      $display("FAIL beep_silent: silent=%b, required 0", silent_a);
    end
    drain("beep");
  endtask

  task automatic test_glitch();
    apply_reset();
    wave_a(100, 100);
    expect_a(200, 100);
    tone_a = 1'b1;
    repeat (10) step();
    tone_a = 1'b0;
    repeat (2) step();
    tone_a = 1'b1;
    repeat (88) step();
    tone_a = 1'b0;
    repeat (100) step();
    expect_a(200, GLITCH_HI);
    tone_a = 1'b1;
    repeat (20) step();
    drain("glitch");
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    wave_b(20, 20);
    expect_b(40, 20);
    wave_b(20, 20);
    n = 0;
    while (n < 400 && silent_b !== 1'b1) begin
      step();
      n++;
    end
    vectors++;
    if (silent_b !== 1'b1 || (cyc - strobe_cyc_b) != 255) begin
      miscompares++;
      $display("FAIL timeout_delay: silent=%b after %0d cycles, required 1 after 255", silent_b, cyc - strobe_cyc_b);
    end else begin
      $display("timeout ok: silent after %0d cycles", cyc - strobe_cyc_b);
    end
    vectors++;
    if (period_b !== 8'd40 || high_b !== 8'd20) begin
      miscompares++;
      $display("FAIL timeout_hold: period=%0d high=%0d, required 40/20", period_b, high_b);
    end
    wave_b(20, 20);
    vectors++;
    if (silent_b !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_rearm_silent: silent=%b, required 1", silent_b);
    end
    expect_b(40, 20);
    wave_b(20, 20);
    vectors++;
    if (silent_b !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_restart_silent: silent=%b, required 0", silent_b);
    end
    drain("timeout");
  endtask

  task automatic test_mid_reset();
    apply_reset();
    wave_a(50, 50);
    expect_a(100, 50);
    wave_a(50, 25);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    vectors++;
    if (silent_a !== 1'b1 || period_a !== '0 || high_a !== '0 || valid_a !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: silent=%b period=%0d high=%0d valid=%b, required 1/0/0/0",
               silent_a, period_a, high_a, valid_a);
    end else begin
      $display("mid_reset ok");
    end
    repeat (10) step();
    wave_a(50, 50);
    expect_a(100, 50);
    wave_a(50, 50);
    drain("mid_reset");
  endtask

  initial begin
    resetn = 1'b0;
    tone_a = 1'b0;
    tone_b = 1'b0;
    test_reset();
    test_square();
    test_beep();
    test_glitch();
    test_timeout();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
